// File: rtl/monpro_final_sub_pkg.sv
// Shared parameters and types for the Montgomery final subtraction stage.
// Default word width, frame length and FSM state encoding.
package monpro_final_sub_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int TOTAL_ADDR_DEF = 128;
  localparam int ADDR_WIDTH_DEF = $clog2(TOTAL_ADDR_DEF);

  typedef enum logic {
    LOAD = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/monpro_final_sub_sub_borrow.sv
// Word-wide subtract-with-borrow cell for the final subtraction stage.
// Produces {borrow, diff} = a - b - bin.
module monpro_final_sub_sub_borrow #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  bin_i,
  output logic [DATA_WIDTH-1:0] diff_o,
  output logic                  bout_o
);

  // One extra bit on the left catches the outgoing borrow.
  assign {bout_o, diff_o} = {1'b0, a_i}
                          - {1'b0, b_i}
                          - {{DATA_WIDTH{1'b0}}, bin_i};

endmodule

// File: rtl/monpro_final_sub.sv
// Final conditional subtraction: R = (T >= N) ? T - N : T, word serial.
// Both candidates are buffered during load; the choice is made at the end.
module monpro_final_sub
  import monpro_final_sub_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TOTAL_ADDR = TOTAL_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_t,
  input  logic [DATA_WIDTH-1:0] in_n,
  input  logic                  in_top,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_r,
  output logic                  out_last,
  output logic                  out_sub
);

  localparam int AW = (TOTAL_ADDR > 1) ? $clog2(TOTAL_ADDR) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(TOTAL_ADDR - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            bw_q, bw_d;
  logic            sel_q, sel_d;

  logic [DATA_WIDTH-1:0] t_buf [TOTAL_ADDR];
  logic [DATA_WIDTH-1:0] d_buf [TOTAL_ADDR];

  logic [DATA_WIDTH-1:0] diff;
  logic                  bout;
  logic                  wr_en;

  monpro_final_sub_sub_borrow #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sub (
    .a_i   (in_t),
    .b_i   (in_n),
    .bin_i (bw_q),
    .diff_o(diff),
    .bout_o(bout)
  );

  assign wr_en   = (state_q == LOAD) & in_valid;
  assign out_sub = sel_q;

  // Next-state, counter, borrow chain and handshake outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bw_d      = bw_q;
    sel_d     = sel_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_r     = '0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bw_d  = bout;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            // Overflow word set means T >= 2^W > N regardless of borrow.
            sel_d   = in_top | ~bout;
            idx_d   = '0;
            bw_d    = 1'b0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_r     = sel_q ? d_buf[idx_q] : t_buf[idx_q];
        out_last  = (idx_q == LAST_IDX);
        if (out_ready) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Control registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      idx_q   <= '0;
      bw_q    <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bw_q    <= bw_d;
      sel_q   <= sel_d;
    end
  end

  // Candidate buffers; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      t_buf[idx_q] <= in_t;
      d_buf[idx_q] <= diff;
    end
  end

endmodule

// File: tb/tb_monpro_final_sub.sv
// Directed bench for monpro_final_sub with 8-bit words, 4-word frames.
// Words are driven and sampled on the falling clock edge.
module tb_monpro_final_sub;

  localparam int DW = 8;
  localparam int TA = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_t;
  logic [DW-1:0] in_n;
  logic          in_top;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_r;
  logic          out_last;
  logic          out_sub;

  int passed = 0;
  int total  = 0;

  localparam logic [31:0] C1_T = 32'h7FFF_FFFF;
  localparam logic [31:0] C1_N = 32'h8000_0001;
  localparam logic [31:0] C1_R = 32'h7FFF_FFFF;
  localparam logic [31:0] C2_T = 32'hC100_123D;
  localparam logic [31:0] C2_N = 32'hC100_123D;
  localparam logic [31:0] C2_R = 32'h0000_0000;
  localparam logic [31:0] C3_T = 32'h0000_0005;
  localparam logic [31:0] C3_N = 32'hFFFF_FFF0;
  localparam logic [31:0] C3_R = 32'h0000_0015;

  monpro_final_sub #(
    .DATA_WIDTH(DW),
    .TOTAL_ADDR(TA)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_t     (in_t),
    .in_n     (in_n),
    .in_top   (in_top),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_r    (out_r),
    .out_last (out_last),
    .out_sub  (out_sub)
  );

  always #5 clk = ~clk;

  // Feeds one frame, starting at a falling edge; ends at the falling
  // edge after the final beat. in_top is inverted on non-final beats.
  task automatic load(input logic [31:0] t, input logic [31:0] n,
                      input logic top);
    for (int i = 0; i < TA; i++) begin
      total++;
      if (in_ready !== 1'b1) begin
        $display("FAIL load_ready beat %0d: got %b want 1", i, in_ready);
      end else passed++;
      in_valid = 1'b1;
      in_t     = t[8*i +: 8];
      in_n     = n[8*i +: 8];
      in_top   = (i == TA - 1) ? top : ~top;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_top   = 1'b0;
  endtask

  // Drains one frame; bp selects an out_ready pattern of 0,1,0,1...
  task automatic unload(input logic [31:0] r, input logic sub,
                        input logic bp, input string nm);
    int w;
    int cyc;
    logic [DW-1:0] exp_w;
    w   = 0;
    cyc = 0;
    while (w < TA && cyc < 40) begin
      out_ready = bp ? (cyc % 2 == 1) : 1'b1;
      exp_w     = r[8*w +: 8];
      total++;
      if (out_valid !== 1'b1) begin
        $display("FAIL %s out_valid w%0d: got %b want 1", nm, w, out_valid);
      end else passed++;
      total++;
      if (out_r !== exp_w) begin
        $display("FAIL %s out_r w%0d: got %h want %h", nm, w, out_r, exp_w);
      end else passed++;
      total++;
      if (out_last !== (w == TA - 1)) begin
        $display("FAIL %s out_last w%0d: got %b want %b", nm, w, out_last,
                 (w == TA - 1));
      end else passed++;
      total++;
      if (out_sub !== sub) begin
        $display("FAIL %s out_sub w%0d: got %b want %b", nm, w, out_sub, sub);
      end else passed++;
      total++;
      if (in_ready !== 1'b0) begin
        $display("FAIL %s in_ready_send w%0d: got %b want 0", nm, w, in_ready);
      end else passed++;
      if (out_ready) w++;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    total++;
    if (w != TA) begin
      $display("FAIL %s timeout: got %0d words want %0d", nm, w, TA);
    end else passed++;
    total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL %s in_ready_after: got %b want 1", nm, in_ready);
    end else passed++;
    total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL %s out_valid_after: got %b want 0", nm, out_valid);
    end else passed++;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_t      = '0;
    in_n      = '0;
    in_top    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL rst_in_ready: got %b want 1", in_ready);
    end else passed++;
    total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL rst_out_valid: got %b want 0", out_valid);
    end else passed++;
    total++;
    if (out_last !== 1'b0) begin
      $display("FAIL rst_out_last: got %b want 0", out_last);
    end else passed++;
    total++;
    if (out_sub !== 1'b0) begin
      $display("FAIL rst_out_sub: got %b want 0", out_sub);
    end else passed++;
    total++;
    if (out_r !== 8'h00) begin
      $display("FAIL rst_out_r: got %h want 00", out_r);
    end else passed++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_less_than();
    load(C1_T, C1_N, 1'b0);
    unload(C1_R, 1'b0, 1'b0, "lt");
  endtask

  task automatic test_equal();
    load(C2_T, C2_N, 1'b0);
    unload(C2_R, 1'b1, 1'b0, "eq");
  endtask

  task automatic test_overflow();
    load(C3_T, C3_N, 1'b1);
    unload(C3_R, 1'b1, 1'b0, "ovf");
  endtask

  task automatic test_backpressure();
    load(C3_T, C3_N, 1'b1);
    unload(C3_R, 1'b1, 1'b1, "bp");
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_t     = C3_T[8*i +: 8];
      in_n     = C3_N[8*i +: 8];
      in_top   = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL mid_rst_in_ready: got %b want 1", in_ready);
    end else passed++;
    total++;
    if (out_valid !== 1'b0) begin
      $display("FAIL mid_rst_out_valid: got %b want 0", out_valid);
    end else passed++;
    total++;
    if (out_sub !== 1'b0) begin
      $display("FAIL mid_rst_out_sub: got %b want 0", out_sub);
    end else passed++;
    total++;
    if (out_last !== 1'b0 || out_r !== 8'h00) begin
      $display("FAIL mid_rst_out: got last=%b r=%h want 0/00",
               out_last, out_r);
    end else passed++;
    #2 reset = 1'b1;
    @(negedge clk);
    load(C1_T, C1_N, 1'b0);
    unload(C1_R, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back();
    load(C1_T, C1_N, 1'b0);
    in_valid = 1'b1;
    in_t     = C2_T[7:0];
    in_n     = C2_N[7:0];
    in_top   = 1'b1;
    unload(C1_R, 1'b0, 1'b0, "b2b_1");
    load(C2_T, C2_N, 1'b0);
    unload(C2_R, 1'b1, 1'b0, "b2b_2");
  endtask

  initial begin
    test_reset();
    test_less_than();
    test_equal();
    test_overflow();
    test_backpressure();
    test_reset_mid_load();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
